// File: rtl/gray_counter_pkg.sv
// Shared constants and Gray/binary conversion helpers for the up/down Gray counter
// and anything that samples its pointer.
package gray_counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Narrower values are zero-extended by the caller; the top bits then stay zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] value);
    logic [31:0] bin;
    bin[31] = value[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ value[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/strobe_divider.sv
// Enable-gated prescaler: asserts tick on every DIV-th enabled cycle. The phase freezes
// while enable is low, and clear restarts it from zero.
module strobe_divider #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  if (DIV <= 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, resetn, clear};
    assign tick      = enable;
  end else begin : g_div
    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] LastPhase = PW'(DIV - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          at_last;

    assign at_last = (phase_q == LastPhase);
    assign tick    = enable & at_last;

    always_comb begin
      phase_d = phase_q;
      if (clear) begin
        phase_d = '0;
      end else if (enable) begin
        phase_d = at_last ? '0 : phase_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_d;
      end
    end
  end

endmodule

// File: rtl/gray_counter_updown.sv
// Parametrised up/down Gray counter with prescaler, synchronous load, wrap/saturate
// limits, terminal-count pulse and change strobe. All outputs come straight from flops.
module gray_counter_updown
  import gray_counter_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned DIV  = 1,
  parameter int unsigned MODE = MODE_WRAP
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic            up_down,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] gray_count,
  output logic [BITS-1:0] bin_count,
  output logic            tc,
  output logic            changed
);

  localparam logic [BITS-1:0] MaxVal = {BITS{1'b1}};

  logic            tick, step;
  logic [BITS-1:0] bin_q, bin_d, gray_q, gray_d, nxt;
  logic            tc_q, tc_d, changed_q, changed_d, at_limit;

  strobe_divider #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .clear  (load),
    .tick   (tick)
  );

  assign step = tick & enable;

  always_comb begin
    bin_d    = bin_q;
    tc_d     = 1'b0;
    nxt      = up_down ? bin_q + 1'b1 : bin_q - 1'b1;
    at_limit = up_down ? (bin_q == MaxVal) : (bin_q == '0);
    if (load) begin
      bin_d = load_value;
    end else if (step) begin
      if (MODE == MODE_SAT) begin
        // Pulse tc on arrival at the limit; further steps against it are dropped.
        if (!at_limit) begin
          bin_d = nxt;
          tc_d  = up_down ? (nxt == MaxVal) : (nxt == '0);
        end
      end else begin
        bin_d = nxt;
        tc_d  = at_limit;
      end
    end
    // Gray follows the next binary value so successive steps flip one bit.
    gray_d    = BITS'(bin2gray(32'(bin_d)));
    changed_d = (gray_d != gray_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q     <= '0;
      gray_q    <= '0;
      tc_q      <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      tc_q      <= tc_d;
      changed_q <= changed_d;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign tc         = tc_q;
  assign changed    = changed_q;

endmodule

// File: doc/gray_counter_updown.md
Name: gray_counter_updown

Overview:
Parametrised successor to the fixed 8-bit up-only Gray counter. It adds:
- configurable width
- an integrated strobe prescaler
- up/down direction
- synchronous load
- wrap or saturate mode
- a terminal-count pulse and a change strobe

It drives LED and status displays on the board directly. It also provides a Gray-coded pointer that can be safely sampled from another clock domain.

Parameters:
BITS, 8, counter width in bits (2..32).
DIV, 1, prescaler divisor: one step opportunity every DIV clk cycles (1..2**24).
MODE, 0, 0 = wrap at limits, 1 = saturate at limits.

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
enable  in  1  count enable; gated with the prescaler tick.
up_down  in  1  1 = count up, 0 = count down; sampled on the step cycle.
load  in  1  synchronous load request.
load_value  in  BITS  binary value to load.
gray_count  out  BITS  registered Gray-coded count.
bin_count  out  BITS  registered binary count, same cycle as gray_count.
tc  out  1  terminal-count pulse, one cycle.
changed  out  1  one-cycle pulse when gray_count updated on this edge.

Behaviour:
- Reset: while resetn=0, asynchronously gray_count=0, bin_count=0, tc=0, changed=0, prescaler phase=0.
- Prescaler: a phase counter of width clog2(DIV) counts 0..DIV-1 and runs only while enable=1.
  - tick=1 on the cycle the phase equals DIV-1; the phase then returns to 0.
  - enable=0 freezes the phase; it does not clear it.
  - DIV=1: tick=enable every cycle.
- step = tick & enable.
- Priority: load > step.
  - load=1: bin_count<=load_value, gray_count<=load_value^(load_value>>1), prescaler phase<=0, tc<=0.
  - changed<=1 on load only if the new gray differs from the old gray.
- Step when up_down=1: next = bin+1. Step when up_down=0: next = bin-1. Arithmetic is modulo 2**BITS.
- Wrap mode (MODE=0):
  - Up from 2**BITS-1 gives 0 with tc=1. Down from 0 gives 2**BITS-1 with tc=1.
  - Otherwise tc=0.
- Saturate mode (MODE=1):
  - A step that would cross a limit holds the value; changed=0 and tc=0.
  - A step that lands on 2**BITS-1 (up) or 0 (down) sets tc=1.
- Latency: gray_count, bin_count, tc and changed all update on the same clk edge as the accepted step or load. There is no extra pipeline stage.
- Gray is computed from the next binary value and registered. Consecutive step updates therefore differ by exactly one bit, including at wrap.
- No step and no load: all registers hold; tc=0, changed=0.
- A direction change takes effect on the next step. No dead step is inserted.
- Reset asserted mid-prescale discards the partial phase. After release, counting resumes from 0, and the first tick comes DIV enabled cycles later.

Decomposition:
- Shared package gray_counter_pkg holds:
  - constants MODE_WRAP=0 and MODE_SAT=1
  - function bin2gray(value)
  - function gray2bin(value), for consumers and the bench
- One sub-module, strobe_divider (parameter DIV; ports clk, resetn, enable, clear, tick), provides the prescaler. Its clear input is driven by load.
- Counter, limit detection and output registers live in gray_counter_updown.

Test Plan:
1. Up count: BITS=4, DIV=1, MODE=0, enable=1, up_down=1 for 16 cycles.
   - gray_count must be 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0.
   - tc=1 only on the 8->0 edge; changed=1 every cycle.
2. Down wrap: reset, then up_down=0 with a single step.
   - Expect bin_count=F, gray_count=8, tc=1.
   - Next step gives bin E, gray 9, tc=0.
3. Saturate: MODE=1, load 0xE, then three up steps.
   - First step: bin F, gray 8, tc=1, changed=1.
   - Next two steps: value held, tc=0, changed=0.
4. Load priority: load=1 with load_value=9 on a step cycle.
   - Expect bin 9, gray D, no increment, tc=0.
   - The next step gives bin A, gray F.
5. Prescaler: DIV=4 with enable held.
   - gray_count updates every 4th cycle.
   - Drop enable for 3 cycles after phase 2: the next update comes 1 enabled cycle after re-enable.
   - Hamming distance is 1 on every changed pulse.
6. Async reset: assert resetn=0 between clock edges at count 0xB.
   - Outputs go to 0 before the next edge.
   - After release, the first update occurs DIV cycles later.
